// File: rtl/wave_voice_scheduler_pkg.sv
// rtl/wave_voice_scheduler_pkg.sv - shared sizes and state type for the wavetable voice scheduler
// Holds the voice count, phase/table/mix widths and the scheduler state enum.
package wave_voice_scheduler_pkg;

    localparam int NUM_VOICES = 4;
    localparam int VOICE_W    = $clog2(NUM_VOICES);
    localparam int PHASE_W    = 24;
    localparam int TABLE_AW   = 9;
    localparam int MIX_W      = 18;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_HOST_WR
    } sched_state_e;

endpackage

// File: rtl/wave_voice_scheduler_phase_bank.sv
// rtl/wave_voice_scheduler_phase_bank.sv - per-voice tuning and phase accumulator register file
// Ports: clk/rst; tune_we/tune_sel/tune_data write a tuning word at any time;
// sel picks the voice whose table address is presented on table_addr;
// advance adds that voice's tuning word to its phase (silent 2^PHASE_W wrap).
module wave_voice_scheduler_phase_bank
    import wave_voice_scheduler_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                tune_we,
    input  logic [VOICE_W-1:0]  tune_sel,
    input  logic [PHASE_W-1:0]  tune_data,
    input  logic [VOICE_W-1:0]  sel,
    input  logic                advance,
    output logic [TABLE_AW-1:0] table_addr
);

    logic [PHASE_W-1:0] tune_q  [NUM_VOICES];
    logic [PHASE_W-1:0] phase_q [NUM_VOICES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                tune_q[i]  <= '0;
                phase_q[i] <= '0;
            end
        end else begin
            if (tune_we) begin
                tune_q[tune_sel] <= tune_data;
            end
            // Uses the tuning word held before any same-cycle tune write.
            if (advance) begin
                phase_q[sel] <= phase_q[sel] + tune_q[sel];
            end
        end
    end

    assign table_addr = phase_q[sel][PHASE_W-1 -: TABLE_AW];

endmodule

// File: rtl/wave_voice_scheduler.sv
// rtl/wave_voice_scheduler.sv - time-multiplexes the wavetable RAM across four voices and a host writer
// Ports: sample_tick starts a 4-voice sweep; tune_* load per-voice phase increments;
// host_req/host_addr/host_wdata/host_ack give one-cycle table writes between sweeps;
// ram_* drive the single-port 512x16 table; voice_* and mix_* carry results;
// busy marks a sweep in progress; overrun pulses when a tick is dropped.
module wave_voice_scheduler
    import wave_voice_scheduler_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_tick,
    input  logic                tune_we,
    input  logic [VOICE_W-1:0]  tune_sel,
    input  logic [PHASE_W-1:0]  tune_data,
    input  logic                host_req,
    input  logic [TABLE_AW-1:0] host_addr,
    input  logic [15:0]         host_wdata,
    output logic                host_ack,
    output logic [TABLE_AW-1:0] ram_addr,
    output logic [15:0]         ram_wdata,
    input  logic [15:0]         ram_rdata,
    output logic                ram_ce,
    output logic                ram_we,
    output logic                ram_re,
    output logic [15:0]         voice_sample,
    output logic [VOICE_W-1:0]  voice_id,
    output logic                voice_valid,
    output logic [MIX_W-1:0]    mix_out,
    output logic                mix_valid,
    output logic                busy,
    output logic                overrun
);

    sched_state_e        state_q, state_d;
    logic [VOICE_W-1:0]  v_q;
    logic                pending_q;
    logic [MIX_W-1:0]    acc_q;
    logic [TABLE_AW-1:0] voice_addr;
    logic                last_voice;
    logic                start_sweep;

    assign last_voice  = (v_q == VOICE_W'(NUM_VOICES - 1));
    assign start_sweep = sample_tick || pending_q;

    wave_voice_scheduler_phase_bank u_phase_bank (
        .clk        (clk),
        .rst        (rst),
        .tune_we    (tune_we),
        .tune_sel   (tune_sel),
        .tune_data  (tune_data),
        .sel        (v_q),
        .advance    (state_q == ST_CAPTURE),
        .table_addr (voice_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        host_ack  = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_sweep) begin
                    state_d = ST_ISSUE;
                end else if (host_req) begin
                    state_d = ST_HOST_WR;
                end
            end
            ST_ISSUE: begin
                ram_addr = voice_addr;
                ram_ce   = 1'b1;
                ram_re   = 1'b1;
                busy     = 1'b1;
                state_d  = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // Address stays put: the RAM's output bank mux follows the live addr[8].
                ram_addr = voice_addr;
                busy     = 1'b1;
                state_d  = last_voice ? ST_IDLE : ST_ISSUE;
            end
            ST_HOST_WR: begin
                ram_addr  = host_addr;
                ram_wdata = host_wdata;
                ram_ce    = 1'b1;
                ram_we    = 1'b1;
                host_ack  = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q          <= '0;
            pending_q    <= 1'b0;
            acc_q        <= '0;
            voice_sample <= '0;
            voice_id     <= '0;
            voice_valid  <= 1'b0;
            mix_out      <= '0;
            mix_valid    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            voice_valid <= 1'b0;
            mix_valid   <= 1'b0;
            overrun     <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_sweep) begin
                        v_q       <= '0;
                        pending_q <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    overrun <= sample_tick;
                end
                ST_CAPTURE: begin
                    overrun      <= sample_tick;
                    voice_sample <= ram_rdata;
                    voice_id     <= v_q;
                    voice_valid  <= 1'b1;
                    if (last_voice) begin
                        mix_out   <= acc_q + MIX_W'(ram_rdata);
                        mix_valid <= 1'b1;
                        acc_q     <= '0;
                    end else begin
                        acc_q <= acc_q + MIX_W'(ram_rdata);
                        v_q   <= v_q + 1'b1;
                    end
                end
                ST_HOST_WR: begin
                    // The write cycle cannot be stretched, so a tick here waits one cycle.
                    if (sample_tick) begin
                        pending_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wave_voice_scheduler.sv
// tb/tb_wave_voice_scheduler.sv - self-checking bench for wave_voice_scheduler with a sine table RAM model
module tb_wave_voice_scheduler;

    logic        clk;
    logic        rst;
    logic        sample_tick;
    logic        tune_we;
    logic [1:0]  tune_sel;
    logic [23:0] tune_data;
    logic        host_req;
    logic [8:0]  host_addr;
    logic [15:0] host_wdata;
    logic        host_ack;
    logic [8:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        ram_ce;
    logic        ram_we;
    logic        ram_re;
    logic [15:0] voice_sample;
    logic [1:0]  voice_id;
    logic        voice_valid;
    logic [17:0] mix_out;
    logic        mix_valid;
    logic        busy;
    logic        overrun;

    wave_voice_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .sample_tick  (sample_tick),
        .tune_we      (tune_we),
        .tune_sel     (tune_sel),
        .tune_data    (tune_data),
        .host_req     (host_req),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .ram_ce       (ram_ce),
        .ram_we       (ram_we),
        .ram_re       (ram_re),
        .voice_sample (voice_sample),
        .voice_id     (voice_id),
        .voice_valid  (voice_valid),
        .mix_out      (mix_out),
        .mix_valid    (mix_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    int m_phase [4];
    int m_tune  [4];
    int m_tab   [512];
    int obs_s   [4];
    int obs_a0;
    int obs_mix;

    function automatic int sine_val(input int a);
        real r;
        r = 32767.5 + 32767.5 * $sin(2.0 * 3.14159265358979 * real'(a) / 512.0);
        return $rtoi($floor(r));
    endfunction

    // Table RAM: registered read of both banks; output bank chosen by the live addr[8].
    logic [15:0] mem [512];
    logic [15:0] lo_q;
    logic [15:0] hi_q;
    bit          init_done;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 512; i++) mem[i] <= 16'(sine_val(i));
            init_done <= 1'b1;
        end else if (ram_ce && ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        if (ram_ce && ram_re) begin
            lo_q <= mem[{1'b0, ram_addr[7:0]}];
            hi_q <= mem[{1'b1, ram_addr[7:0]}];
        end
    end
    assign ram_rdata = ram_addr[8] ? hi_q : lo_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_phase[i] = 0;
            m_tune[i]  = 0;
        end
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic set_tune(input int v, input int d);
        tune_we   = 1'b1;
        tune_sel  = 2'(v);
        tune_data = 24'(d);
        step();
        tune_we   = 1'b0;
        m_tune[v] = d & 32'hFFFFFF;
    endtask

    task automatic host_write(input int a, input int d, input bit tick_in_wr);
        step();
        host_req   = 1'b1;
        host_addr  = 9'(a);
        host_wdata = 16'(d);
        @(negedge clk);
        check("host_ack_pre", 32'(host_ack), 0);
        step();
        sample_tick = tick_in_wr;
        @(negedge clk);
        check("host_ack", 32'(host_ack), 1);
        check("host_ram_addr", 32'(ram_addr), a);
        check("host_ram_we", 32'({ram_ce, ram_we, ram_re}), 32'b110);
        check("host_ram_wdata", 32'(ram_wdata), d);
        step();
        host_req    = 1'b0;
        sample_tick = 1'b0;
        @(negedge clk);
        check("host_ack_post", 32'(host_ack), 0);
        m_tab[a] = d;
    endtask

    // Sweep started by a tick in the current cycle (or by a pending tick): checks all 9 cycles.
    task automatic sweep_check(input bit send_tick);
        int a [4];
        int s [4];
        int mix;
        int vi;
        mix = 0;
        for (int i = 0; i < 4; i++) begin
            a[i] = (m_phase[i] >> 15) & 511;
            s[i] = m_tab[a[i]];
            mix += s[i];
        end
        sample_tick = send_tick;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            sample_tick = 1'b0;
            @(negedge clk);
            check("busy", 32'(busy), 32'(k <= 8));
            check("voice_valid", 32'(voice_valid), 32'(k >= 3 && k % 2 == 1));
            check("mix_valid", 32'(mix_valid), 32'(k == 9));
            if (k <= 8) begin
                check("ram_addr", 32'(ram_addr), a[(k - 1) / 2]);
                check("ram_re", 32'(ram_re), 32'(k % 2 == 1));
                if (k == 1) obs_a0 = int'(ram_addr);
            end
            if (k >= 3 && k % 2 == 1) begin
                vi = (k - 3) / 2;
                check("voice_id", 32'(voice_id), vi);
                check("voice_sample", 32'(voice_sample), s[vi]);
                obs_s[vi] = int'(voice_sample);
            end
            if (k == 9) begin
                check("mix_out", 32'(mix_out), mix);
                obs_mix = int'(mix_out);
            end
        end
        for (int i = 0; i < 4; i++) m_phase[i] = (m_phase[i] + m_tune[i]) & 32'hFFFFFF;
    endtask

    initial begin
        int exp4 [4];
        int nmix;
        int ha;
        int hd;
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        sample_tick = 1'b0;
        tune_we     = 1'b0;
        tune_sel    = '0;
        tune_data   = '0;
        host_req    = 1'b0;
        host_addr   = '0;
        host_wdata  = '0;
        for (int i = 0; i < 512; i++) m_tab[i] = sine_val(i);
        model_reset();

        step();
        step();
        @(negedge clk);
        check("rst_flags", 32'({voice_valid, mix_valid, busy, ram_ce, ram_we, ram_re, host_ack, overrun}), 0);
        check("rst_sample", 32'(voice_sample), 0);
        check("rst_mix", 32'(mix_out), 0);
        check("rst_addr", 32'(ram_addr), 0);
        step();
        rst = 1'b0;

        // All tunes zero: every voice reads table[0].
        sweep_check(1'b1);
        check("t1_v0", obs_s[0], 32'h7FFF);
        check("t1_v3", obs_s[3], 32'h7FFF);
        check("t1_mix", obs_mix, 32'h1FFFC);

        // One address step per tick on voice 0.
        do_reset();
        set_tune(0, 32'h008000);
        sweep_check(1'b1);
        check("t2_s0", obs_s[0], 32'h7FFF);
        sweep_check(1'b1);
        check("t2_s1", obs_s[0], 32'h8191);
        sweep_check(1'b1);
        check("t2_s2", obs_s[0], 32'h8323);
        check("t2_v1", obs_s[1], 32'h7FFF);

        // Quarter-table steps: both banks, then the phase wraps back to address 0.
        do_reset();
        set_tune(0, 32'h400000);
        exp4[0] = 32'h7FFF;
        exp4[1] = 32'hFFFF;
        exp4[2] = 32'h7FFF;
        exp4[3] = 32'h0000;
        for (int t = 0; t < 4; t++) begin
            sweep_check(1'b1);
            check("t3_sample", obs_s[0], exp4[t]);
        end
        sweep_check(1'b1);
        check("t3_wrap_addr", obs_a0, 0);

        // Host write then read back through voice 0.
        do_reset();
        host_write(5, 32'h1234, 1'b0);
        set_tune(0, 32'h028000);
        sweep_check(1'b1);
        check("t4_first", obs_s[0], 32'h7FFF);
        sweep_check(1'b1);
        check("t4_host", obs_s[0], 32'h1234);

        // Tick during a sweep is dropped with an overrun pulse.
        do_reset();
        sample_tick = 1'b1;
        nmix = 0;
        for (int k = 1; k <= 14; k++) begin
            step();
            sample_tick = (k == 4);
            @(negedge clk);
            check("overrun", 32'(overrun), 32'(k == 5));
            if (mix_valid) nmix++;
        end
        check("one_mix", nmix, 1);

        // Tick coincident with host_req: sweep first, write acknowledged at T+10.
        step();
        ha = int'($urandom_range(1, 511));
        hd = int'($urandom_range(0, 65535));
        sample_tick = 1'b1;
        host_req    = 1'b1;
        host_addr   = 9'(ha);
        host_wdata  = 16'(hd);
        for (int k = 1; k <= 10; k++) begin
            step();
            sample_tick = 1'b0;
            @(negedge clk);
            check("coinc_ack", 32'(host_ack), 32'(k == 10));
            if (k == 9) check("coinc_mix", 32'(mix_valid), 1);
        end
        step();
        host_req = 1'b0;
        m_tab[ha] = hd;
        set_tune(2, ha << 15);
        sweep_check(1'b1);
        sweep_check(1'b1);
        check("coinc_read", obs_s[2], hd);

        // Reset in the middle of a sweep.
        do_reset();
        for (int v = 0; v < 4; v++) set_tune(v, int'($urandom & 32'hFFFFFF));
        sample_tick = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            sample_tick = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("mid_rst_flags", 32'({voice_valid, mix_valid, busy, ram_ce, ram_re, overrun}), 0);
        check("mid_rst_sample", 32'(voice_sample), 0);
        check("mid_rst_id", 32'(voice_id), 0);
        step();
        step();
        rst = 1'b0;
        model_reset();
        repeat (8) begin
            @(negedge clk);
            check("post_rst_quiet", 32'({voice_valid, mix_valid, busy}), 0);
            step();
        end
        sweep_check(1'b1);
        check("post_rst_addr", obs_a0, 0);
        check("post_rst_v3", obs_s[3], 32'h7FFF);

        // Randomized tunes and table writes, alternating direct and pending ticks.
        for (int it = 0; it < 6; it++) begin
            for (int v = 0; v < 4; v++) set_tune(v, int'($urandom & 32'hFFFFFF));
            host_write(int'($urandom_range(1, 511)), int'($urandom_range(0, 65535)), it[0]);
            if (it[0]) sweep_check(1'b0);
            else sweep_check(1'b1);
            sweep_check(1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
